// File: rtl/pipe_pkg.sv
// Shared constants and the state encoding for the fetch/decode skid register.
package pipe_pkg;

  localparam logic [31:0] PC_RST_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register (main + skid) with flush bubble insertion
// and a saturating downstream-stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W = 32,
  parameter int              PC_W   = 32,
  parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RST_DEFAULT),
  parameter int              CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e              state_q;
  logic [PC_W-1:0]     main_pc_q;
  logic [DATA_W-1:0]   main_instr_q;
  logic [PC_W-1:0]     skid_pc_q;
  logic [DATA_W-1:0]   skid_instr_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;
  logic                accept_s;
  logic                consume_s;

  // Handshake flags come straight from the state register, never from inputs.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign accept_s  = in_valid & in_ready;
  assign consume_s = out_valid & out_ready;

  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;
  assign stall_cnt = stall_cnt_q;

  // Occupancy FSM together with the main and skid entry registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= PC_RST;
      main_instr_q <= DATA_W'(NOP_INSTR);
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else if (flush) begin
      // Bubble: drop everything, keep the PC so the bubble is traceable.
      state_q      <= ST_EMPTY;
      main_instr_q <= DATA_W'(NOP_INSTR);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_pc_q    <= in_pc;
            main_instr_q <= in_instr;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept_s && consume_s) begin
            main_pc_q    <= in_pc;
            main_instr_q <= in_instr;
          end else if (accept_s) begin
            skid_pc_q    <= in_pc;
            skid_instr_q <= in_instr;
            state_q      <= ST_FULL;
          end else if (consume_s) begin
            state_q      <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume_s) begin
            main_pc_q    <= skid_pc_q;
            main_instr_q <= skid_instr_q;
            state_q      <= ST_BUSY;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating increment while the head entry is being held back.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
